// File: rtl/reservation_station.sv
// reservation_station: buffers dispatched ops until their operands arrive
// on the CDB, then issues the lowest ready entry through a registered stage.
module reservation_station #(
   parameter int DEPTH = 4,
   parameter int OP_W  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         disp_valid,
   output logic                         disp_ready,
   input  logic [OP_W-1:0]              disp_op,
   input  logic [4:0]                   disp_dest_tag,
   input  logic                         disp_qj_pend,
   input  logic                         disp_qk_pend,
   input  logic [4:0]                   disp_qj,
   input  logic [4:0]                   disp_qk,
   input  logic [31:0]                  disp_vj,
   input  logic [31:0]                  disp_vk,
   input  logic                         cdb_valid,
   input  logic [4:0]                   cdb_tag,
   input  logic [31:0]                  cdb_value,
   output logic                         issue_valid,
   input  logic                         issue_ready,
   output logic [OP_W-1:0]              issue_op,
   output logic [4:0]                   issue_dest_tag,
   output logic [31:0]                  issue_vj,
   output logic [31:0]                  issue_vk,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] pend_j;
   logic [DEPTH-1:0] pend_k;
   logic [OP_W-1:0]  op_q   [DEPTH];
   logic [4:0]       dest_q [DEPTH];
   logic [4:0]       qj_q   [DEPTH];
   logic [4:0]       qk_q   [DEPTH];
   logic [31:0]      vj_q   [DEPTH];
   logic [31:0]      vk_q   [DEPTH];

   logic [DEPTH-1:0] elig;
   logic [IW-1:0]    free_idx;
   logic             free_any;
   logic [IW-1:0]    sel_idx;
   logic             sel_any;
   logic             load;
   logic             disp_fire;
   logic             hit_j;
   logic             hit_k;
   logic [31:0]      new_vj;
   logic [31:0]      new_vk;

   assign elig       = busy & ~pend_j & ~pend_k;
   assign disp_ready = free_any;
   assign load       = (!issue_valid || issue_ready) && sel_any;
   assign disp_fire  = disp_valid && free_any && !flush;

   // A pending operand whose producer broadcasts this cycle is captured at dispatch.
   assign hit_j  = cdb_valid && disp_qj_pend && (disp_qj == cdb_tag);
   assign hit_k  = cdb_valid && disp_qk_pend && (disp_qk == cdb_tag);
   assign new_vj = hit_j ? cdb_value : disp_vj;
   assign new_vk = hit_k ? cdb_value : disp_vk;

   // Lowest free slot and lowest eligible slot, scanned high to low so low wins.
   always_comb begin
      free_idx = '0;
      free_any = 1'b0;
      sel_idx  = '0;
      sel_any  = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_idx = IW'(i);
            free_any = 1'b1;
         end
         if (elig[i]) begin
            sel_idx = IW'(i);
            sel_any = 1'b1;
         end
      end
   end

   // Occupancy is the population count of busy slots.
   always_comb begin
      count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count = count + CW'(busy[i]);
      end
   end

   // Entry storage: dispatch writes, CDB snoop wakes, issue frees.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy   <= '0;
         pend_j <= '0;
         pend_k <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]   <= '0;
            dest_q[i] <= '0;
            qj_q[i]   <= '0;
            qk_q[i]   <= '0;
            vj_q[i]   <= '0;
            vk_q[i]   <= '0;
         end
      end else if (flush) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (load && sel_idx == IW'(i)) begin
               busy[i] <= 1'b0;
            end
            if (disp_fire && free_idx == IW'(i)) begin
               busy[i]   <= 1'b1;
               op_q[i]   <= disp_op;
               dest_q[i] <= disp_dest_tag;
               pend_j[i] <= disp_qj_pend && !hit_j;
               pend_k[i] <= disp_qk_pend && !hit_k;
               qj_q[i]   <= disp_qj;
               qk_q[i]   <= disp_qk;
               vj_q[i]   <= new_vj;
               vk_q[i]   <= new_vk;
            end else if (busy[i] && cdb_valid) begin
               if (pend_j[i] && qj_q[i] == cdb_tag) begin
                  pend_j[i] <= 1'b0;
                  vj_q[i]   <= cdb_value;
               end
               if (pend_k[i] && qk_q[i] == cdb_tag) begin
                  pend_k[i] <= 1'b0;
                  vk_q[i]   <= cdb_value;
               end
            end
         end
      end
   end

   // Output stage: load on a free or draining slot, hold under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_valid    <= 1'b0;
         issue_op       <= '0;
         issue_dest_tag <= '0;
         issue_vj       <= '0;
         issue_vk       <= '0;
      end else if (flush) begin
         issue_valid <= 1'b0;
      end else if (load) begin
         issue_valid    <= 1'b1;
         issue_op       <= op_q[sel_idx];
         issue_dest_tag <= dest_q[sel_idx];
         issue_vj       <= vj_q[sel_idx];
         issue_vk       <= vk_q[sel_idx];
      end else if (issue_ready) begin
         issue_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios plus randomized traffic
// compared every cycle against a behavioural slot model.
module tb_reservation_station;

   localparam int DEPTH = 4;
   localparam int OP_W  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        disp_valid;
   logic        disp_ready;
   logic [3:0]  disp_op;
   logic [4:0]  disp_dest_tag;
   logic        disp_qj_pend;
   logic        disp_qk_pend;
   logic [4:0]  disp_qj;
   logic [4:0]  disp_qk;
   logic [31:0] disp_vj;
   logic [31:0] disp_vk;
   logic        cdb_valid;
   logic [4:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        issue_valid;
   logic        issue_ready;
   logic [3:0]  issue_op;
   logic [4:0]  issue_dest_tag;
   logic [31:0] issue_vj;
   logic [31:0] issue_vk;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   reservation_station #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_op(disp_op), .disp_dest_tag(disp_dest_tag),
      .disp_qj_pend(disp_qj_pend), .disp_qk_pend(disp_qk_pend),
      .disp_qj(disp_qj), .disp_qk(disp_qk),
      .disp_vj(disp_vj), .disp_vk(disp_vk),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_op(issue_op), .issue_dest_tag(issue_dest_tag),
      .issue_vj(issue_vj), .issue_vk(issue_vk),
      .count(count)
   );

   always #5 clk = ~clk;

   // Behavioural model: a list of slots plus one output register.
   typedef struct {
      bit        busy;
      bit [3:0]  op;
      bit [4:0]  dest;
      bit        pj;
      bit        pk;
      bit [4:0]  qj;
      bit [4:0]  qk;
      bit [31:0] vj;
      bit [31:0] vk;
   } slot_t;

   slot_t     m [DEPTH];
   bit        m_iv;
   bit [3:0]  m_iop;
   bit [4:0]  m_idest;
   bit [31:0] m_ivj;
   bit [31:0] m_ivk;

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) if (m[i].busy) n++;
      return n;
   endfunction

   function automatic bit m_ready();
      return m_count() < DEPTH;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m[i] = '{default: 0};
      m_iv = 0; m_iop = 0; m_idest = 0; m_ivj = 0; m_ivk = 0;
   endtask

   task automatic model_clock();
      slot_t n [DEPTH];
      int sel;
      int fr;
      bit hj;
      bit hk;
      if (rst) begin
         model_reset();
         return;
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
         m_iv = 0;
         return;
      end
      n = m;
      if (cdb_valid) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (m[i].busy && m[i].pj && m[i].qj == cdb_tag) begin
               n[i].pj = 0; n[i].vj = cdb_value;
            end
            if (m[i].busy && m[i].pk && m[i].qk == cdb_tag) begin
               n[i].pk = 0; n[i].vk = cdb_value;
            end
         end
      end
      sel = -1;
      for (int i = 0; i < DEPTH; i++)
         if (sel < 0 && m[i].busy && !m[i].pj && !m[i].pk) sel = i;
      if (!m_iv || issue_ready) begin
         if (sel >= 0) begin
            m_iv = 1; m_iop = m[sel].op; m_idest = m[sel].dest;
            m_ivj = m[sel].vj; m_ivk = m[sel].vk;
            n[sel].busy = 0;
         end else begin
            m_iv = 0;
         end
      end
      fr = -1;
      for (int i = 0; i < DEPTH; i++)
         if (fr < 0 && !m[i].busy) fr = i;
      if (disp_valid && fr >= 0) begin
         hj = disp_qj_pend && cdb_valid && disp_qj == cdb_tag;
         hk = disp_qk_pend && cdb_valid && disp_qk == cdb_tag;
         n[fr].busy = 1;
         n[fr].op = disp_op;
         n[fr].dest = disp_dest_tag;
         n[fr].pj = disp_qj_pend && !hj;
         n[fr].pk = disp_qk_pend && !hk;
         n[fr].qj = disp_qj;
         n[fr].qk = disp_qk;
         n[fr].vj = hj ? cdb_value : disp_vj;
         n[fr].vk = hk ? cdb_value : disp_vk;
      end
      m = n;
   endtask

   // One clock: model follows the edge, then inputs may change 1ns later.
   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; disp_valid = 0; disp_op = 0; disp_dest_tag = 0;
      disp_qj_pend = 0; disp_qk_pend = 0; disp_qj = 0; disp_qk = 0;
      disp_vj = 0; disp_vk = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
      issue_ready = 1;
   endtask

   task automatic set_disp(input bit [3:0] op, input bit [4:0] dest,
                           input bit pj, input bit [4:0] qj, input bit [31:0] vj,
                           input bit pk, input bit [4:0] qk, input bit [31:0] vk);
      disp_valid = 1; disp_op = op; disp_dest_tag = dest;
      disp_qj_pend = pj; disp_qj = qj; disp_vj = vj;
      disp_qk_pend = pk; disp_qk = qk; disp_vk = vk;
   endtask

   task automatic settle(input int n);
      idle_inputs();
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      model_reset();
      #2;
      checks++;
      if ({issue_valid, count, disp_ready, issue_op, issue_dest_tag, issue_vj, issue_vk}
          !== {1'b0, 3'd0, 1'b1, 4'd0, 5'd0, 32'd0, 32'd0})
         begin errors++; $display("FAIL reset_state got v=%0b cnt=%0d rdy=%0b op=%0d want 0/0/1/0",
                                  issue_valid, count, disp_ready, issue_op); end
      step();
      step();
      rst = 0;
      settle(2);
   endtask

   task automatic test_ready_dispatch();
      settle(3);
      set_disp(3, 5, 0, 0, 10, 0, 0, 20);
      step();
      disp_valid = 0;
      checks++;
      if ({issue_valid, count} !== {1'b0, 3'd1})
         begin errors++; $display("FAIL ready_c1 got v=%0b cnt=%0d want v=0 cnt=1", issue_valid, count); end
      step();
      checks++;
      if ({issue_valid, count, issue_op, issue_dest_tag, issue_vj, issue_vk}
          !== {1'b1, 3'd0, 4'd3, 5'd5, 32'd10, 32'd20})
         begin errors++; $display("FAIL ready_c2 got v=%0b cnt=%0d op=%0d dst=%0d vj=%0d vk=%0d want 1 0 3 5 10 20",
                                  issue_valid, count, issue_op, issue_dest_tag, issue_vj, issue_vk); end
   endtask

   task automatic test_wakeup();
      settle(3);
      set_disp(1, 6, 1, 7, 0, 0, 0, 2);
      step();
      disp_valid = 0;
      step();
      cdb_valid = 0; cdb_tag = 7; cdb_value = 32'h1234;
      step();
      cdb_valid = 1; cdb_tag = 7; cdb_value = 32'hDEADBEEF;
      step();
      cdb_valid = 0;
      checks++;
      if ({issue_valid, count} !== {1'b0, 3'd1})
         begin errors++; $display("FAIL wakeup_c4 got v=%0b cnt=%0d want v=0 cnt=1", issue_valid, count); end
      step();
      checks++;
      if ({issue_valid, issue_dest_tag, issue_vj, issue_vk} !== {1'b1, 5'd6, 32'hDEADBEEF, 32'd2})
         begin errors++; $display("FAIL wakeup_c5 got v=%0b dst=%0d vj=%h vk=%0d want 1 6 deadbeef 2",
                                  issue_valid, issue_dest_tag, issue_vj, issue_vk); end
   endtask

   task automatic test_bypass_multi();
      settle(3);
      set_disp(2, 8, 0, 0, 1, 1, 9, 0);
      cdb_valid = 1; cdb_tag = 9; cdb_value = 32'h55;
      step();
      idle_inputs();
      step();
      checks++;
      if ({issue_valid, issue_dest_tag, issue_vj, issue_vk} !== {1'b1, 5'd8, 32'd1, 32'h55})
         begin errors++; $display("FAIL bypass got v=%0b dst=%0d vj=%0d vk=%h want 1 8 1 55",
                                  issue_valid, issue_dest_tag, issue_vj, issue_vk); end
      settle(3);
      set_disp(4, 11, 1, 4, 0, 0, 0, 7);
      step();
      set_disp(4, 12, 1, 4, 0, 0, 0, 8);
      step();
      disp_valid = 0;
      cdb_valid = 1; cdb_tag = 4; cdb_value = 32'h44;
      step();
      cdb_valid = 0;
      checks++;
      if ({issue_valid, count} !== {1'b0, 3'd2})
         begin errors++; $display("FAIL multi_c3 got v=%0b cnt=%0d want 0 2", issue_valid, count); end
      step();
      checks++;
      if ({issue_valid, issue_dest_tag, issue_vj, issue_vk} !== {1'b1, 5'd11, 32'h44, 32'd7})
         begin errors++; $display("FAIL multi_first got dst=%0d vj=%h want 11 44", issue_dest_tag, issue_vj); end
      step();
      checks++;
      if ({issue_valid, issue_dest_tag, issue_vj, issue_vk} !== {1'b1, 5'd12, 32'h44, 32'd8})
         begin errors++; $display("FAIL multi_second got dst=%0d vj=%h want 12 44", issue_dest_tag, issue_vj); end
   endtask

   task automatic test_full_backpressure();
      int exp_dest [4] = '{22, 21, 23, 24};
      settle(3);
      issue_ready = 0;
      for (int d = 20; d <= 24; d++) begin
         set_disp(4'(d), 5'(d), 0, 0, 32'(d * 2), 0, 0, 32'(d));
         step();
         if (d >= 21) begin
            checks++;
            if ({issue_valid, issue_dest_tag, issue_vj} !== {1'b1, 5'd20, 32'd40})
               begin errors++; $display("FAIL hold_d%0d got v=%0b dst=%0d vj=%0d want 1 20 40",
                                        d, issue_valid, issue_dest_tag, issue_vj); end
         end
      end
      disp_valid = 0;
      checks++;
      if ({disp_ready, count} !== {1'b0, 3'd4})
         begin errors++; $display("FAIL full got rdy=%0b cnt=%0d want 0 4", disp_ready, count); end
      issue_ready = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if ({issue_valid, issue_dest_tag, disp_ready, count} !== {1'b1, 5'(exp_dest[k]), 1'b1, 3'(3 - k)})
            begin errors++; $display("FAIL drain_%0d got v=%0b dst=%0d rdy=%0b cnt=%0d want 1 %0d 1 %0d",
                                     k, issue_valid, issue_dest_tag, disp_ready, count, exp_dest[k], 3 - k); end
      end
      step();
      checks++;
      if ({issue_valid, count} !== {1'b0, 3'd0})
         begin errors++; $display("FAIL drain_end got v=%0b cnt=%0d want 0 0", issue_valid, count); end
   endtask

   task automatic test_flush();
      settle(3);
      issue_ready = 0;
      for (int d = 1; d <= 4; d++) begin
         set_disp(1, 5'(d), 0, 0, 0, 0, 0, 0);
         step();
      end
      checks++;
      if ({issue_valid, count} !== {1'b1, 3'd3})
         begin errors++; $display("FAIL preflush got v=%0b cnt=%0d want 1 3", issue_valid, count); end
      set_disp(2, 30, 0, 0, 0, 0, 0, 0);
      cdb_valid = 1; cdb_tag = 3; cdb_value = 1;
      flush = 1;
      step();
      idle_inputs();
      issue_ready = 0;
      checks++;
      if ({issue_valid, count, disp_ready} !== {1'b0, 3'd0, 1'b1})
         begin errors++; $display("FAIL flush got v=%0b cnt=%0d rdy=%0b want 0 0 1",
                                  issue_valid, count, disp_ready); end
      step();
      checks++;
      if ({issue_valid, count} !== {1'b0, 3'd0})
         begin errors++; $display("FAIL postflush got v=%0b cnt=%0d want 0 0", issue_valid, count); end
   endtask

   task automatic test_async_reset();
      settle(3);
      issue_ready = 0;
      set_disp(5, 17, 0, 0, 99, 0, 0, 98);
      step();
      set_disp(6, 18, 0, 0, 1, 0, 0, 2);
      step();
      disp_valid = 0;
      #2;
      rst = 1;
      #1;
      checks++;
      if ({issue_valid, count, disp_ready, issue_op, issue_dest_tag, issue_vj, issue_vk}
          !== {1'b0, 3'd0, 1'b1, 4'd0, 5'd0, 32'd0, 32'd0})
         begin errors++; $display("FAIL async_rst got v=%0b cnt=%0d rdy=%0b dst=%0d vj=%0d want 0 0 1 0 0",
                                  issue_valid, count, disp_ready, issue_dest_tag, issue_vj); end
      model_reset();
      #1;
      rst = 0;
      settle(2);
   endtask

   task automatic test_random();
      settle(3);
      for (int c = 0; c < 600; c++) begin
         disp_valid    = ($urandom_range(0, 99) < 55);
         disp_op       = 4'($urandom);
         disp_dest_tag = 5'($urandom);
         disp_qj_pend  = ($urandom_range(0, 99) < 40);
         disp_qk_pend  = ($urandom_range(0, 99) < 40);
         disp_qj       = 5'($urandom_range(0, 3));
         disp_qk       = 5'($urandom_range(0, 3));
         disp_vj       = $urandom;
         disp_vk       = $urandom;
         cdb_valid     = ($urandom_range(0, 99) < 40);
         cdb_tag       = 5'($urandom_range(0, 3));
         cdb_value     = $urandom;
         issue_ready   = ($urandom_range(0, 99) < 60);
         flush         = ($urandom_range(0, 99) < 3);
         step();
         checks++;
         if ({issue_valid, count, disp_ready, issue_op, issue_dest_tag, issue_vj, issue_vk}
             !== {m_iv, 3'(m_count()), m_ready(), m_iop, m_idest, m_ivj, m_ivk})
            begin errors++; $display("FAIL rand_c%0d got v=%0b cnt=%0d rdy=%0b op=%0d dst=%0d vj=%h vk=%h want v=%0b cnt=%0d rdy=%0b op=%0d dst=%0d vj=%h vk=%h",
                                     c, issue_valid, count, disp_ready, issue_op, issue_dest_tag, issue_vj, issue_vk,
                                     m_iv, m_count(), m_ready(), m_iop, m_idest, m_ivj, m_ivk); end
      end
      settle(2);
   endtask

   initial begin
      test_reset();
      test_ready_dispatch();
      test_wakeup();
      test_bypass_multi();
      test_full_backpressure();
      test_flush();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reservation_station.md
# reservation_station

CDB consumer for one execution unit. Holds dispatched instructions whose source operands may still be pending. Snoops the Common Data Bus (valid/tag/value) to capture those operands. Issues ready instructions, lowest index first, through a registered valid/ready output stage. It sits between the dispatch stage and the ALU, on the receiving end of the CDB arbiter's broadcast.

## Interface
- DEPTH, 4: number of entries (power of two, ≥2).
- OP_W, 4: opcode width.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of all entries and the output stage.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  at least one free entry.
- disp_op  in  OP_W  opcode.
- disp_dest_tag  in  5  ROB/result tag of the instruction.
- disp_qj_pend, disp_qk_pend  in  1 each  operand j/k still pending (1 = waiting on a tag).
- disp_qj, disp_qk  in  5 each  producer tag for pending operand.
- disp_vj, disp_vk  in  32 each  operand value when not pending.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  5  broadcast tag.
- cdb_value  in  32  broadcast value.
- issue_valid  out  1  output stage holds an instruction.
- issue_ready  in  1  execution unit accepts.
- issue_op  out  OP_W  opcode.
- issue_dest_tag  out  5  result tag.
- issue_vj, issue_vk  out  32 each  resolved operands.
- count  out  $clog2(DEPTH+1)  occupied entries, output stage excluded.

## Operation
- Entry state: busy, op, dest_tag, pend_j/qj/vj, pend_k/qk/vk.
- Dispatch fires on disp_valid && disp_ready && !flush. Writes the lowest-index free entry.
- disp_ready = any entry not busy, from registered state only. An entry freed in the same cycle gives no credit.
- A CDB match requires cdb_valid. cdb_tag is ignored when cdb_valid=0, including tag 0.
- Snoop: every busy entry with pend_j && qj==cdb_tag captures vj=cdb_value and clears pend_j. Operand k is handled the same way.
- All matching entries capture on the same broadcast. Both operands of one entry may capture at once.
- Dispatch bypass: if a dispatched pending operand's tag matches the CDB in the same cycle, the entry is written with the value and pend=0.
- qX is ignored when disp_qX_pend=0.
- Eligible: busy && !pend_j && !pend_k, evaluated on registered state.
- Output stage loads when (!issue_valid || issue_ready) and some entry is eligible.
  - It takes the lowest-index eligible entry and frees that entry on the same edge.
  - If issue_valid && issue_ready and nothing is eligible, issue_valid falls.
- The output stage holds op, dest_tag, vj, vk stable while issue_valid && !issue_ready.
- count tracks the busy entries: +1 on dispatch, −1 on move to the output stage, both on the same edge give net 0.
- flush: on the next edge all busy=0, issue_valid=0, count=0. Dispatch and CDB capture in the flush cycle are discarded.
- Reset: all busy=0, issue_valid=0, issue_* data 0, count=0, disp_ready=1.

## Timing
- Dispatch with both operands ready, accepted in cycle t: issue_valid=1 in cycle t+2 if the output stage is free.
- An operand arriving on the CDB in cycle t, or bypassed at dispatch in cycle t: the instruction becomes eligible in t+1 and issue_valid=1 in t+2 at the earliest.
- Back-to-back issue: with issue_ready held at 1 and entries eligible, one instruction transfers per cycle.
- Full: with DEPTH busy entries, disp_ready=0. It rises the cycle after an entry moves to the output stage.
- Backpressure: issue_ready=0 stalls the output stage only. Snooping and dispatch continue.
- Reset asserted mid-operation clears state immediately, without waiting for an edge.

## Test plan
- Ready dispatch: cycle 0 dispatch op=3, dest=5, vj=10, vk=20, no pending → issue_valid in cycle 2 with op=3, dest=5, vj=10, vk=20; count 1 in cycle 1, 0 in cycle 2.
- Wakeup: dispatch with qj=7 pending; cdb_valid, tag=7, value=0xDEADBEEF in cycle 3 → issue_vj=0xDEADBEEF, issue_valid in cycle 5. cdb_valid=0 with tag 7 in cycle 2 causes no capture.
- Bypass and multi-match: dispatch qk=9 pending in the same cycle as a CDB tag=9, value=0x55 → entry ready, issue_vk=0x55. Two entries both waiting on tag 4 capture from one broadcast.
- Full/backpressure: fill 4 entries with issue_ready=0 → disp_ready=0, count=4 after the output stage loads entry 0 (count=3, one entry freed). Output data stays stable. Raising issue_ready drains in index order 0,1,2,3 at one per cycle.
- Flush/reset: flush with 3 busy entries and issue_valid=1 → next cycle issue_valid=0, count=0, disp_ready=1. Async rst asserted between edges zeroes all outputs immediately.
